// File: rtl/id_hazard_scoreboard_if.sv
// Purpose: decode-stage hazard/forwarding bundle between ID control and the hazard scoreboard.
// Latency: carries combinational stall/fwd_sel; no registers of its own.
// Backpressure: stall tells ID to hold its instruction; hold freezes the downstream shadow pipeline.
interface id_hazard_scoreboard_if #(
  parameter int IDX_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2
);
  logic                     id_valid;
  logic                     id_reg_wr;
  logic                     id_is_load;
  logic [IDX_W-1:0]         id_dest_idx;
  logic [NUM_SRC*IDX_W-1:0] id_src_idx;
  logic [NUM_SRC-1:0]       id_src_used;
  logic                     hold;
  logic                     flush;
  logic                     stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [SEL_W-1:0]         inflight_cnt;

  // Decode/control side: presents the ID instruction and pipeline controls.
  modport master (
    output id_valid, id_reg_wr, id_is_load, id_dest_idx, id_src_idx, id_src_used,
           hold, flush,
    input  stall, fwd_sel, inflight_cnt
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_reg_wr, id_is_load, id_dest_idx, id_src_idx, id_src_used,
           hold, flush,
    output stall, fwd_sel, inflight_cnt
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Purpose: RAW hazard detection and bypass-select generation for the decode stage (shadow pipeline of dest tags).
// Latency: stall/fwd_sel/inflight_cnt are combinational from slot state; slot state advances one slot per cycle.
// Backpressure: stall holds ID; hold freezes every slot; flush kills the youngest FLUSH_SLOTS slots.
// Build option: define HAZARD_FWD_EN to enable forwarding; otherwise any in-flight producer stalls.
module id_hazard_scoreboard #(
  parameter int IDX_W       = 5,
  parameter int NUM_SRC     = 2,
  parameter int DEPTH       = 3,
  parameter int ALU_READY   = 2,
  parameter int LD_READY    = 3,
  parameter int FLUSH_SLOTS = 1,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  id_hazard_scoreboard_if.slave bus
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic             vld;
    logic             ld;
    logic [IDX_W-1:0] idx;
  } slot_t;

  // Slot k models the instruction k stages past ID (1 = EX ... DEPTH = WB).
  slot_t slot_q [1:DEPTH];
  slot_t slot_d [1:DEPTH];
  slot_t slot_new;

  logic                     issue;
  logic                     stall_c;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
  logic [SEL_W-1:0]         cnt_c;

  logic                     op_hit  [NUM_SRC];
  logic                     op_rdy  [NUM_SRC];
  logic [SEL_W-1:0]         op_slot [NUM_SRC];

  // The ID instruction enters EX only when it is neither stalled nor frozen.
  assign issue = bus.id_valid & ~stall_c & ~bus.hold;

  // Tag entering slot 1: writes to the zero register never create a dependency.
  always_comb begin
    slot_new.vld = issue & bus.id_reg_wr & (bus.id_dest_idx != '0);
    slot_new.ld  = bus.id_is_load;
    slot_new.idx = bus.id_dest_idx;
  end

  // Next slot state: shift unless held, then flush kills the youngest slots on top of that.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (!bus.hold) begin
      slot_d[1] = slot_new;
      for (int k = 2; k <= DEPTH; k++) begin
        slot_d[k] = slot_q[k-1];
      end
    end
    if (bus.flush) begin
      for (int k = 1; k <= FLUSH_SLOTS && k <= DEPTH; k++) begin
        slot_d[k].vld = 1'b0;
      end
    end
  end

  // Shadow pipeline registers; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Per-operand youngest match: scan oldest to youngest so the lowest slot number wins.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      op_hit[i]  = 1'b0;
      op_rdy[i]  = 1'b0;
      op_slot[i] = '0;
      if (bus.id_valid && bus.id_src_used[i] &&
          (bus.id_src_idx[i*IDX_W +: IDX_W] != '0)) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (slot_q[k].vld && (slot_q[k].idx == bus.id_src_idx[i*IDX_W +: IDX_W])) begin
            op_hit[i]  = 1'b1;
            op_slot[i] = SEL_W'(k);
            op_rdy[i]  = (k >= (slot_q[k].ld ? LD_READY : ALU_READY));
          end
        end
      end
    end
  end

  // Forward a ready youngest producer when bypassing is built in; anything else stalls ID.
  always_comb begin
    stall_c   = 1'b0;
    fwd_sel_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (op_hit[i]) begin
        if (FWD_EN && op_rdy[i]) begin
          fwd_sel_c[i*SEL_W +: SEL_W] = op_slot[i];
        end else begin
          stall_c = 1'b1;
        end
      end
    end
  end

  // Occupancy: popcount of valid slots.
  always_comb begin
    cnt_c = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      cnt_c = cnt_c + {{(SEL_W-1){1'b0}}, slot_q[k].vld};
    end
  end

  assign bus.stall        = stall_c;
  assign bus.fwd_sel      = fwd_sel_c;
  assign bus.inflight_cnt = cnt_c;

endmodule
